// File: rtl/run_monitor.sv
// Run controller for the single-cycle core: gates execution, counts RUN cycles,
// ends the run on a tohost store or a timeout, and traces register writes into a FIFO.
module run_monitor #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 1000,
    parameter int TOHOST_ADDR = 64,
    parameter int PASS_VALUE  = 1,
    parameter int TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rf_we,
    input  logic [RA_W-1:0]  rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             dm_we,
    input  logic [XLEN-1:0]  dm_addr,
    input  logic [XLEN-1:0]  dm_wdata,
    input  logic             trace_rd,
    output logic             core_run,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic             trace_valid,
    output logic [RA_W-1:0]  trace_addr,
    output logic [XLEN-1:0]  trace_data,
    output logic             trace_overflow
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int ENT_W = RA_W + XLEN;
    localparam logic [PTR_W:0] WRAP = {1'b1, {PTR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t           state;
    logic [ENT_W-1:0] mem [TRACE_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             capture, empty, full, do_push, do_pop, drop, tohost;
    logic [ENT_W-1:0] push_entry, head_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
        capture    = (state == RUN) && rf_we && (rf_waddr != '0);
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr == (rd_ptr ^ WRAP));
        do_pop     = trace_rd && !empty;
        do_push    = capture && (!full || do_pop);
        drop       = capture && full && !do_pop;
        wr_nxt     = wr_ptr + {{PTR_W{1'b0}}, do_push};
        rd_nxt     = rd_ptr + {{PTR_W{1'b0}}, do_pop};
        push_entry = {rf_waddr, rf_wdata};
        tohost     = dm_we && (dm_addr == XLEN'(TOHOST_ADDR));
        head_nxt   = {trace_addr, trace_data};
        // The next head is the entry being written this cycle when the FIFO was empty
        // or is about to drain to exactly that slot; otherwise it is already in memory.
        if (wr_nxt != rd_nxt) begin
            if (do_push && (rd_nxt[PTR_W-1:0] == wr_ptr[PTR_W-1:0]))
                head_nxt = push_entry;
            else
                head_nxt = mem[rd_nxt[PTR_W-1:0]];
        end
    end

    // NOTE: trace storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            core_run       <= 1'b0;
            cycle_count    <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_code      <= 2'b00;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_valid    <= 1'b0;
            trace_addr     <= '0;
            trace_data     <= '0;
            trace_overflow <= 1'b0;
        end else begin
            wr_ptr                   <= wr_nxt;
            rd_ptr                   <= rd_nxt;
            trace_valid              <= (wr_nxt != rd_nxt);
            {trace_addr, trace_data} <= head_nxt;
            case (state)
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    if (drop)
                        trace_overflow <= 1'b1;
                    if (tohost) begin
                        core_run <= 1'b0;
                        done     <= 1'b1;
                        if (dm_wdata == XLEN'(PASS_VALUE)) begin
                            state <= PASS;
                            pass  <= 1'b1;
                        end else begin
                            state     <= FAIL;
                            fail_code <= 2'b10;
                        end
                    end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                        state     <= FAIL;
                        core_run  <= 1'b0;
                        done      <= 1'b1;
                        fail_code <= 2'b01;
                    end
                end
                default: begin
                    if (start) begin
                        state                    <= RUN;
                        core_run                 <= 1'b1;
                        cycle_count              <= '0;
                        done                     <= 1'b0;
                        pass                     <= 1'b0;
                        fail_code                <= 2'b00;
                        wr_ptr                   <= '0;
                        rd_ptr                   <= '0;
                        trace_valid              <= 1'b0;
                        {trace_addr, trace_data} <= {trace_addr, trace_data};
                        trace_overflow           <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: stimulus queues expected trace pops and run
// results; a negedge monitor compares them whenever the DUT presents them.
module tb_run_monitor;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 16;
    localparam int MAXC  = 10;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             rf_we = 1'b0;
    logic [RA_W-1:0]  rf_waddr = '0;
    logic [XLEN-1:0]  rf_wdata = '0;
    logic             dm_we = 1'b0;
    logic [XLEN-1:0]  dm_addr = '0;
    logic [XLEN-1:0]  dm_wdata = '0;
    logic             trace_rd = 1'b0;
    logic             core_run;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic             trace_valid;
    logic [RA_W-1:0]  trace_addr;
    logic [XLEN-1:0]  trace_data;
    logic             trace_overflow;

    always #5 clk = ~clk;

    run_monitor #(
        .XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W), .MAX_CYCLES(MAXC),
        .TOHOST_ADDR(64), .PASS_VALUE(1), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .trace_rd(trace_rd), .core_run(core_run), .cycle_count(cycle_count),
        .done(done), .pass(pass), .fail_code(fail_code),
        .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_overflow(trace_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [RA_W+XLEN-1:0] exp_trace [$];
    logic [CNT_W+2:0]     exp_done  [$];  // {pass, fail_code, cycle_count}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled by the next one.
    task automatic cyc(input logic s, input logic we, input logic [RA_W-1:0] ra,
                       input logic [XLEN-1:0] rv, input logic dwe,
                       input logic [XLEN-1:0] da, input logic [XLEN-1:0] dd, input logic rd);
        @(posedge clk);
        #1;
        start = s; rf_we = we; rf_waddr = ra; rf_wdata = rv;
        dm_we = dwe; dm_addr = da; dm_wdata = dd; trace_rd = rd;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rfw(input logic [RA_W-1:0] ra, input logic [XLEN-1:0] rv, input logic push_exp);
        cyc(0, 1, ra, rv, 0, 0, 0, 0);
        if (push_exp) exp_trace.push_back({ra, rv});
    endtask

    task automatic pop1();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compares the head on every accepted pop and the result on every rising done.
    initial begin
        logic done_prev;
        logic [RA_W+XLEN-1:0] e;
        logic [CNT_W+2:0] r;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && trace_rd && trace_valid) begin
                if (exp_trace.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL trace_unexpected: got %0h expected none", {trace_addr, trace_data});
                end else begin
                    e = exp_trace.pop_front();
                    check("trace_entry", 64'({trace_addr, trace_data}), 64'(e));
                end
            end
            if (done && !done_prev) begin
                if (exp_done.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_unexpected: got %0h expected none", {pass, fail_code, cycle_count});
                end else begin
                    r = exp_done.pop_front();
                    check("run_result", 64'({pass, fail_code, cycle_count}), 64'(r));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        // Reset then idle
        #13;
        check("rst_core_run", 64'(core_run), 0);
        check("rst_trace_valid", 64'(trace_valid), 0);
        rst = 1'b1;
        idle(5);
        @(negedge clk);
        check("idle_core_run", 64'(core_run), 0);
        check("idle_done", 64'(done), 0);
        check("idle_cycle_count", 64'(cycle_count), 0);
        check("idle_trace_valid", 64'(trace_valid), 0);

        // Pass run: tohost store in RUN cycle 6, capture on the terminating cycle too
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        check("start_core_run", 64'(core_run), 1);
        check("start_cycle_count", 64'(cycle_count), 0);
        rfw(1, 5, 1);
        rfw(3, 7, 1);
        rfw(0, 9, 0);
        cyc(0, 0, 0, 0, 1, 16, 3, 0);
        idle(1);
        exp_done.push_back({1'b1, 2'b00, 16'd7});
        cyc(0, 1, 2, 32'h22, 1, 64, 1, 0);
        exp_trace.push_back({5'd2, 32'h22});
        idle(3);
        @(negedge clk);
        check("pass_core_run", 64'(core_run), 0);
        check("pass_frozen_count", 64'(cycle_count), 7);
        pop1(); pop1(); pop1();
        idle(1);
        @(negedge clk);
        check("pass_fifo_empty", 64'(trace_valid), 0);

        // Bad tohost value from a restart in PASS
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        rfw(5, 32'hAA, 0);
        exp_done.push_back({1'b0, 2'b10, 16'd2});
        cyc(0, 0, 0, 0, 1, 64, 3, 0);
        idle(2);
        @(negedge clk);
        check("bad_done", 64'(done), 1);
        check("bad_trace_held", 64'(trace_valid), 1);

        // Restart from FAIL clears everything, then time out (start mid-run ignored)
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        check("restart_flushed", 64'(trace_valid), 0);
        check("restart_flags", 64'({done, pass, fail_code}), 0);
        check("restart_count", 64'(cycle_count), 0);
        exp_done.push_back({1'b0, 2'b01, 16'd10});
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        @(negedge clk);
        check("timeout_count", 64'(cycle_count), MAXC);
        check("timeout_core_run", 64'(core_run), 0);

        // Tohost pass store on the timeout cycle wins
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(9);
        exp_done.push_back({1'b1, 2'b00, 16'd10});
        cyc(0, 0, 0, 0, 1, 64, 1, 0);
        idle(2);
        @(negedge clk);
        check("tie_pass", 64'(pass), 1);

        // Overflow, then full FIFO with a simultaneous push and pop
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            rfw(RA_W'(i), XLEN'(32'h10 + i), i <= DEPTH);
        cyc(0, 1, 7, 32'h17, 0, 0, 0, 1);
        exp_trace.push_back({5'd7, 32'h17});
        @(negedge clk);
        check("ovf_sticky", 64'(trace_overflow), 1);
        exp_done.push_back({1'b1, 2'b00, 16'd8});
        cyc(0, 0, 0, 0, 1, 64, 1, 0);
        idle(1);
        pop1(); pop1(); pop1(); pop1(); pop1();
        idle(1);
        @(negedge clk);
        check("ovf_empty_after_four", 64'(trace_valid), 0);
        check("ovf_head_held", 64'({trace_addr, trace_data}), 64'({5'd7, 32'h17}));
        check("ovf_after_done", 64'(trace_overflow), 1);

        // Async reset in the middle of a run
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        rfw(4, 32'h44, 0);
        idle(2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_core_run", 64'(core_run), 0);
        check("arst_trace_valid", 64'(trace_valid), 0);
        check("arst_outputs", 64'({cycle_count, done, pass, fail_code, trace_overflow}), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        @(negedge clk);
        check("arst_idle", 64'({core_run, done, cycle_count}), 0);

        check("trace_queue_drained", 64'(exp_trace.size()), 0);
        check("done_queue_drained", 64'(exp_done.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
